// File: rtl/snake_scan_feeder.sv
// Streams a frame out of the frame SRAM in the PE-array snake order.
// A two-entry skid FIFO absorbs the 1-cycle SRAM latency and consumer backpressure.
module snake_scan_feeder #(
  parameter int ROW     = 128,
  parameter int COL     = 128,
  parameter int CH      = 4,
  parameter int PEA_NUM = 32,
  parameter int ADDR_W  = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [CH*8-1:0]      mem_rdata,
  output logic [PEA_NUM*8-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int RW = $clog2(ROW + 1);
  localparam int CW = (COL > 1) ? $clog2(COL) : 1;
  localparam logic [CW-1:0]     COL_LAST = CW'(COL - 1);
  localparam logic [RW-1:0]     ROW_LAST = RW'(ROW - 1);
  localparam logic [ADDR_W-1:0] COL_A    = ADDR_W'(COL);

  typedef enum logic [1:0] {IDLE, PAIR, SNAKE, DRAIN} state_t;

  state_t              state, state_n;
  logic [RW-1:0]       row, row_n;
  logic [CW-1:0]       col, col_n;
  logic [ADDR_W-1:0]   base, base_n;
  logic                rd_pending;
  logic [CH*8-1:0]     fifo_q [2];
  logic                wr_ptr, rd_ptr;
  logic [1:0]          count;
  logic                push, pop, issue, issue_ok;
  logic [2:0]          occ;

  assign push       = rd_pending;
  assign data_valid = (count != 2'd0);
  assign pop        = data_valid && data_ready;
  // Occupancy after this cycle's pop, so a full-rate stream never bubbles.
  assign occ        = {1'b0, count} + {2'b0, rd_pending} - {2'b0, pop};
  assign issue_ok   = (occ < 3'd2);

  assign mem_rd_en  = issue;
  assign mem_addr   = base + ADDR_W'(col);
  assign busy       = (state != IDLE);

  always_comb begin
    data_out           = '0;
    data_out[CH*8-1:0] = fifo_q[rd_ptr];
  end

  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    base_n  = base;
    issue   = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = PAIR;
          row_n   = '0;
          col_n   = '0;
          base_n  = '0;
        end
      end
      PAIR: begin
        // base toggles between row 0 and row 1 within each column.
        if (issue_ok) begin
          issue = 1'b1;
          if (base == '0) begin
            base_n = COL_A;
          end else if (col == COL_LAST) begin
            base_n  = COL_A + COL_A;
            row_n   = RW'(2);
            col_n   = COL_LAST;
            state_n = (ROW > 2) ? SNAKE : DRAIN;
          end else begin
            base_n = '0;
            col_n  = col + CW'(1);
          end
        end
      end
      SNAKE: begin
        if (issue_ok) begin
          issue = 1'b1;
          if (!row[0]) begin
            if (col == '0) begin
              row_n  = row + RW'(1);
              base_n = base + COL_A;
            end else begin
              col_n = col - CW'(1);
            end
          end else if (col == COL_LAST) begin
            if (row == ROW_LAST) begin
              state_n = DRAIN;
            end else begin
              row_n  = row + RW'(1);
              base_n = base + COL_A;
            end
          end else begin
            col_n = col + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (count == 2'd0 && !rd_pending) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      base  <= '0;
    end else begin
      state <= state_n;
      row   <= row_n;
      col   <= col_n;
      base  <= base_n;
    end
  end

  // Read data lands in the FIFO the cycle it returns; reset drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pending <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      rd_pending <= issue;
      if (push) begin
        fifo_q[wr_ptr] <= mem_rdata;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_scan_feeder.sv
// Bench for snake_scan_feeder: 4x3, 2x4 and 128x128 frames with SRAM models,
// a cycle table for the first frame and scoreboarded multi-cycle scenarios.
module tb_snake_scan_feeder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b1;
  int   sel = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  logic         a_rd, b_rd, c_rd;
  logic [13:0]  a_addr, b_addr, c_addr;
  logic [31:0]  a_rdata, b_rdata, c_rdata;
  logic [255:0] a_data, b_data, c_data;
  logic         a_valid, b_valid, c_valid;
  logic         a_busy, b_busy, c_busy;
  logic         a_done, b_done, c_done;
  logic         a_start, b_start, c_start;

  assign a_start = start && (sel == 0);
  assign b_start = start && (sel == 1);
  assign c_start = start && (sel == 2);

  snake_scan_feeder #(.ROW(4), .COL(3)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .mem_rd_en(a_rd), .mem_addr(a_addr),
    .mem_rdata(a_rdata), .data_out(a_data), .data_valid(a_valid), .data_ready(ready),
    .busy(a_busy), .done(a_done));

  snake_scan_feeder #(.ROW(2), .COL(4)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .mem_rd_en(b_rd), .mem_addr(b_addr),
    .mem_rdata(b_rdata), .data_out(b_data), .data_valid(b_valid), .data_ready(ready),
    .busy(b_busy), .done(b_done));

  snake_scan_feeder u_c (
    .clk(clk), .rst(rst), .start(c_start), .mem_rd_en(c_rd), .mem_addr(c_addr),
    .mem_rdata(c_rdata), .data_out(c_data), .data_valid(c_valid), .data_ready(ready),
    .busy(c_busy), .done(c_done));

  // SRAM models with one cycle of read latency.
  always_ff @(posedge clk) begin
    if (a_rd) a_rdata <= {18'b0, a_addr};
    if (b_rd) b_rdata <= {18'b0, b_addr};
    if (c_rd) c_rdata <= {4{c_addr[7:0]}};
  end

  logic         cur_rd, cur_valid, cur_busy, cur_done;
  logic [13:0]  cur_addr;
  logic [255:0] cur_data;

  always_comb begin
    cur_rd = a_rd; cur_valid = a_valid; cur_busy = a_busy; cur_done = a_done;
    cur_addr = a_addr; cur_data = a_data;
    if (sel == 1) begin
      cur_rd = b_rd; cur_valid = b_valid; cur_busy = b_busy; cur_done = b_done;
      cur_addr = b_addr; cur_data = b_data;
    end else if (sel == 2) begin
      cur_rd = c_rd; cur_valid = c_valid; cur_busy = c_busy; cur_done = c_done;
      cur_addr = c_addr; cur_data = c_data;
    end
  end

  typedef struct {
    logic       start;
    logic       ready;
    logic       exp_rd;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_done;
    logic       exp_busy;
  } vec_t;

  vec_t tbl [17];

  logic [31:0] got [$];
  int first_rd, first_v, last_acc, done_cyc, done_cnt, done_ovl;
  int stall_err, outst_err, upper_nz, issued;
  bit aborted;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] golden(input int s, input int idx);
    int rows, cols, r, c, k, a;
    rows = (s == 0) ? 4 : ((s == 1) ? 2 : 128);
    cols = (s == 0) ? 3 : ((s == 1) ? 4 : 128);
    if (idx < 2 * cols) begin
      r = idx % 2;
      c = idx / 2;
    end else begin
      k = idx - 2 * cols;
      r = 2 + k / cols;
      c = (r % 2 == 0) ? (cols - 1 - k % cols) : (k % cols);
    end
    a = r * cols + c;
    if (rows < 2) a = 0;
    if (s == 2) return {4{a[7:0]}};
    return 32'(a);
  endfunction

  // Drives one per-cycle table row and compares the DUT against it.
  task automatic applyStimulus(input int i);
    @(negedge clk);
    start = tbl[i].start;
    ready = tbl[i].ready;
    #1;
    checkOutput($sformatf("tbl%0d_rd", i), cur_rd, tbl[i].exp_rd);
    checkOutput($sformatf("tbl%0d_valid", i), cur_valid, tbl[i].exp_valid);
    checkOutput($sformatf("tbl%0d_done", i), cur_done, tbl[i].exp_done);
    checkOutput($sformatf("tbl%0d_busy", i), cur_busy, tbl[i].exp_busy);
    if (tbl[i].exp_valid)
      checkOutput($sformatf("tbl%0d_data", i), cur_data[63:0], {56'b0, tbl[i].exp_data});
  endtask

  // mode 0: ready always; 1: 3-cycle stalls on beats 2 and 7; 2: random ready.
  task automatic runFrame(input int s, input int mode, input int restart_at,
                          input int abort_at, input int budget);
    int stall_left;
    bit st2, st7, restarted, fin;
    logic pv, pr;
    logic [255:0] pd;
    sel = s;
    got.delete();
    first_rd = -1; first_v = -1; last_acc = -1; done_cyc = -1;
    done_cnt = 0; done_ovl = 0; stall_err = 0; outst_err = 0; upper_nz = 0; issued = 0;
    aborted = 0; stall_left = 0; st2 = 0; st7 = 0; restarted = 0; fin = 0;
    pv = 0; pr = 0; pd = '0;
    for (int c = 0; c < budget && !fin; c++) begin
      @(negedge clk);
      start = (c == 0);
      if (restart_at >= 0 && !restarted && got.size() == restart_at && cur_valid) begin
        start = 1'b1;
        restarted = 1;
      end
      if (abort_at >= 0 && got.size() == abort_at) begin
        rst = 1'b1;
        aborted = 1;
        break;
      end
      ready = 1'b1;
      if (mode == 1) begin
        if (stall_left > 0) begin
          ready = 1'b0;
          stall_left--;
        end else if (cur_valid && got.size() == 2 && !st2) begin
          st2 = 1; ready = 1'b0; stall_left = 2;
        end else if (cur_valid && got.size() == 7 && !st7) begin
          st7 = 1; ready = 1'b0; stall_left = 2;
        end
      end else if (mode == 2) begin
        ready = ($urandom_range(0, 3) != 0);
      end
      #1;
      if (pv && !pr && !(cur_valid === 1'b1 && cur_data === pd)) stall_err++;
      if (cur_rd) begin
        if (first_rd < 0) first_rd = c;
        issued++;
      end
      if (cur_valid && first_v < 0) first_v = c;
      if (cur_done) begin
        done_cnt++;
        done_cyc = c;
        if (cur_valid) done_ovl++;
        fin = 1;
      end
      if (cur_valid && ready) begin
        got.push_back(cur_data[31:0]);
        if (cur_data[255:32] != '0) upper_nz++;
        last_acc = c;
      end
      if (issued - int'(got.size()) > 2) outst_err++;
      pv = cur_valid; pr = ready; pd = cur_data;
    end
    start = 1'b0;
    ready = 1'b1;
  endtask

  task automatic checkFrame(input string tag, input int s, input int beats, input bit full_rate);
    int mism, first_bad;
    mism = 0; first_bad = -1;
    checkOutput({tag, "_beats"}, got.size(), beats);
    foreach (got[i]) begin
      if (got[i] !== golden(s, i)) begin
        mism++;
        if (first_bad < 0) first_bad = i;
      end
    end
    checkOutput($sformatf("%s_order(first bad %0d)", tag, first_bad), mism, 0);
    checkOutput({tag, "_upper_zero"}, upper_nz, 0);
    checkOutput({tag, "_stall_stable"}, stall_err, 0);
    checkOutput({tag, "_outstanding"}, outst_err, 0);
    checkOutput({tag, "_done_count"}, done_cnt, 1);
    checkOutput({tag, "_done_vs_valid"}, done_ovl, 0);
    checkOutput({tag, "_done_latency"}, done_cyc - last_acc, 1);
    checkOutput({tag, "_first_rd"}, first_rd, 1);
    checkOutput({tag, "_first_valid"}, first_v, 3);
    if (full_rate) checkOutput({tag, "_no_bubbles"}, last_acc - first_v, beats - 1);
    @(negedge clk);
    #1;
    checkOutput({tag, "_busy_after"}, cur_busy, 0);
    checkOutput({tag, "_done_after"}, cur_done, 0);
  endtask

  initial begin
    logic [7:0] seq4x3 [12];
    int quiet_bad;
    seq4x3 = '{8'd0, 8'd3, 8'd1, 8'd4, 8'd2, 8'd5, 8'd8, 8'd7, 8'd6, 8'd9, 8'd10, 8'd11};
    for (int i = 0; i < 17; i++) begin
      tbl[i].start     = (i == 0);
      tbl[i].ready     = 1'b1;
      tbl[i].exp_rd    = (i >= 1 && i <= 12);
      tbl[i].exp_valid = (i >= 3 && i <= 14);
      tbl[i].exp_data  = (i >= 3 && i <= 14) ? seq4x3[i - 3] : 8'd0;
      tbl[i].exp_done  = (i == 15);
      tbl[i].exp_busy  = (i >= 1 && i <= 15);
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("reset_valid", a_valid, 0);
    checkOutput("reset_busy", a_busy, 0);
    checkOutput("reset_done", a_done, 0);
    checkOutput("reset_rd_en", a_rd, 0);
    checkOutput("reset_data", a_data[63:0], 0);
    checkOutput("reset_addr", a_addr, 0);
    checkOutput("reset_busy_c", c_busy, 0);

    $display("[TB] 4x3 frame, cycle table");
    sel = 0;
    for (int i = 0; i < 17; i++) applyStimulus(i);

    $display("[TB] 4x3 frame with backpressure");
    runFrame(0, 1, -1, -1, 200);
    checkFrame("bp4x3", 0, 12, 1'b0);

    $display("[TB] 2x4 frame");
    runFrame(1, 0, -1, -1, 200);
    checkFrame("f2x4", 1, 8, 1'b1);

    $display("[TB] 4x3 frame with start re-pulsed at beat 5");
    runFrame(0, 0, 5, -1, 200);
    checkFrame("restart", 0, 12, 1'b1);

    $display("[TB] 4x3 frame with reset at beat 6");
    runFrame(0, 0, -1, 6, 200);
    checkOutput("abort_reached", aborted, 1);
    @(negedge clk);
    #1;
    checkOutput("abort_valid", a_valid, 0);
    checkOutput("abort_busy", a_busy, 0);
    checkOutput("abort_rd_en", a_rd, 0);
    rst = 1'b0;
    quiet_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (a_done || a_valid || a_busy) quiet_bad++;
    end
    checkOutput("abort_quiet", quiet_bad, 0);
    runFrame(0, 0, -1, -1, 200);
    checkFrame("replay", 0, 12, 1'b1);

    $display("[TB] 128x128 frame with random ready");
    runFrame(2, 2, -1, -1, 40000);
    checkFrame("f128", 2, 16384, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
